// File: rtl/lane_demand_sensor_pkg.sv
// Shared definitions for the traffic-light slice: controller state codes, lamp patterns and
// default sizing of the lane demand sensor.
package lane_demand_sensor_pkg;

  // Controller state codes (A green, A yellow, B green, B yellow).
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } tlc_state_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LampRed    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam lamp_t LampYellow = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam lamp_t LampGreen  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

  localparam int unsigned DefaultQw          = 4;
  localparam int unsigned DefaultDebCycles   = 4;
  localparam int unsigned DefaultDepartTicks = 8;

  function automatic lamp_t lamp_a(tlc_state_e st);
    lamp_t l;
    unique case (st)
      S0:      l = LampGreen;
      S1:      l = LampYellow;
      default: l = LampRed;
    endcase
    return l;
  endfunction

  function automatic lamp_t lamp_b(tlc_state_e st);
    lamp_t l;
    unique case (st)
      S2:      l = LampGreen;
      S3:      l = LampYellow;
      default: l = LampRed;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/lane_demand_sensor_lane_queue.sv
// One lane of the demand sensor: synchronise and debounce the detector, count queued vehicles
// and drain the count one vehicle per DEPART_TICKS green cycles.
module lane_queue
  import lane_demand_sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DefaultDebCycles,
  parameter int unsigned DEPART_TICKS = DefaultDepartTicks,
  parameter int unsigned QW           = DefaultQw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          det,
  input  logic          green,
  output logic          t,
  output logic [QW-1:0] q,
  output logic          ovf
);

  localparam int unsigned CntW  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TickW = (DEPART_TICKS > 1) ? $clog2(DEPART_TICKS) : 1;

  localparam logic [CntW-1:0]  CntMax   = CntW'(DEB_CYCLES);
  localparam logic [TickW-1:0] TickLast = TickW'(DEPART_TICKS - 1);
  localparam logic [QW-1:0]    QMax     = {QW{1'b1}};

  logic             s1_q, s2_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             deb, deb_q, arr;
  logic [TickW-1:0] tick_q, tick_d;
  logic             dep, dep_eff;
  logic [QW-1:0]    q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             t_q, t_d;

  // Debounce: run length of synchronised-high cycles, saturating at DEB_CYCLES.
  always_comb begin
    cnt_d = '0;
    if (s2_q) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    end
  end

  assign deb = (cnt_q == CntMax);
  assign arr = deb & ~deb_q;

  // Departure timer: a partial green interval is thrown away when green drops.
  always_comb begin
    tick_d = '0;
    dep    = 1'b0;
    if (green) begin
      if (tick_q == TickLast) begin
        dep = 1'b1;
      end else begin
        tick_d = tick_q + TickW'(1);
      end
    end
  end

  assign dep_eff = dep & (q_q != '0);

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (arr && !dep_eff) begin
      if (q_q == QMax) begin
        ovf_d = 1'b1;
      end else begin
        q_d = q_q + QW'(1);
      end
    end else if (dep_eff && !arr) begin
      q_d = q_q - QW'(1);
    end
    t_d = (q_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      tick_q <= '0;
      q_q    <= '0;
      ovf_q  <= 1'b0;
      t_q    <= 1'b0;
    end else begin
      s1_q   <= det;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      deb_q  <= deb;
      tick_q <= tick_d;
      q_q    <= q_d;
      ovf_q  <= ovf_d;
      t_q    <= t_d;
    end
  end

  assign t   = t_q;
  assign q   = q_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/lane_demand_sensor.sv
// Two-lane vehicle demand sensor feeding TA/TB to the traffic-light controller.
module lane_demand_sensor
  import lane_demand_sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DefaultDebCycles,
  parameter int unsigned DEPART_TICKS = DefaultDepartTicks,
  parameter int unsigned QW           = DefaultQw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          det_a,
  input  logic          det_b,
  input  logic          GA,
  input  logic          GB,
  output logic          TA,
  output logic          TB,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qb,
  output logic          ovf_a,
  output logic          ovf_b
);

  lane_queue #(
    .DEB_CYCLES  (DEB_CYCLES),
    .DEPART_TICKS(DEPART_TICKS),
    .QW          (QW)
  ) u_lane_a (
    .clk  (clk),
    .rst  (rst),
    .det  (det_a),
    .green(GA),
    .t    (TA),
    .q    (qa),
    .ovf  (ovf_a)
  );

  lane_queue #(
    .DEB_CYCLES  (DEB_CYCLES),
    .DEPART_TICKS(DEPART_TICKS),
    .QW          (QW)
  ) u_lane_b (
    .clk  (clk),
    .rst  (rst),
    .det  (det_b),
    .green(GB),
    .t    (TB),
    .q    (qb),
    .ovf  (ovf_b)
  );

endmodule

// File: tb/tb_lane_demand_sensor.sv
// Bench for lane_demand_sensor: directed scenarios plus randomized traffic against a
// run-length based reference model.
module tb_lane_demand_sensor;

  localparam int DEB  = 4;
  localparam int DT   = 8;
  localparam int QMAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       det_a = 1'b0, det_b = 1'b0, GA = 1'b0, GB = 1'b0;
  logic       TA, TB, ovf_a, ovf_b;
  logic [3:0] qa, qb;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: queue, overflow, recent detector run lengths, green run length.
  int m_q[2];
  bit m_ovf[2];
  int m_run[2][4];
  int m_grun[2];

  lane_demand_sensor dut (
    .clk  (clk),
    .rst  (rst),
    .det_a(det_a),
    .det_b(det_b),
    .GA   (GA),
    .GB   (GB),
    .TA   (TA),
    .TB   (TB),
    .qa   (qa),
    .qb   (qb),
    .ovf_a(ovf_a),
    .ovf_b(ovf_b)
  );

  always #5 clk = ~clk;

  // An arrival is credited 3 edges after the detector has been seen high DEB samples in a row;
  // a departure occurs on every DT-th consecutive green edge.
  task automatic model_edge();
    logic d, g;
    int   nr;
    bit   arr, dep;
    for (int l = 0; l < 2; l++) begin
      d = (l == 0) ? det_a : det_b;
      g = (l == 0) ? GA : GB;
      if (rst) begin
        m_q[l]    = 0;
        m_ovf[l]  = 1'b0;
        m_grun[l] = 0;
        for (int i = 0; i < 4; i++) m_run[l][i] = 0;
      end else begin
        nr = d ? m_run[l][0] + 1 : 0;
        if (nr > 1000) nr = 1000;
        m_run[l][3] = m_run[l][2];
        m_run[l][2] = m_run[l][1];
        m_run[l][1] = m_run[l][0];
        m_run[l][0] = nr;
        arr = (m_run[l][3] == DEB);
        m_grun[l] = g ? m_grun[l] + 1 : 0;
        dep = g && (m_grun[l] % DT == 0) && (m_q[l] > 0);
        if (arr && !dep) begin
          if (m_q[l] == QMAX) m_ovf[l] = 1'b1;
          else m_q[l]++;
        end else if (dep && !arr) begin
          m_q[l]--;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; det_a = 1'b0; det_b = 1'b0; GA = 1'b0; GB = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // n separate qualified pulses on one lane; each lands 2 edges into its low phase.
  task automatic arrive(input int lane, input int n);
    for (int k = 0; k < n; k++) begin
      if (lane == 0) det_a = 1'b1; else det_b = 1'b1;
      for (int i = 0; i < 5; i++) step();
      if (lane == 0) det_a = 1'b0; else det_b = 1'b0;
      for (int i = 0; i < 3; i++) step();
    end
    step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; det_a = 1'b1; det_b = 1'b1; GA = 1'b0; GB = 1'b0;
    step(); step();
    n_checks++;
    if ({TA, TB, qa, qb, ovf_a, ovf_b} !== 12'd0) begin
      $display("FAIL reset_outputs: got %b expected all zero", {TA, TB, qa, qb, ovf_a, ovf_b});
    end else n_pass++;
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) begin
        n_checks++;
        if (qa !== 4'd0 || qb !== 4'd0) begin
          $display("FAIL reset_early: qa=%0d qb=%0d expected 0 0 at edge 6", qa, qb);
        end else n_pass++;
      end
      if (e == 7) begin
        n_checks++;
        if (qa !== 4'd1 || qb !== 4'd1 || TA !== 1'b1 || TB !== 1'b1) begin
          $display("FAIL reset_first_arrival: qa=%0d qb=%0d TA=%b TB=%b expected 1 1 1 1",
                   qa, qb, TA, TB);
        end else n_pass++;
      end
    end
    det_a = 1'b0; det_b = 1'b0;
  endtask

  task automatic test_glitch();
    bit bad = 1'b0;
    do_reset();
    det_a = 1'b1;
    for (int i = 0; i < 3; i++) step();
    det_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (qa !== 4'd0 || TA !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL glitch: qa=%0d TA=%b expected 0 0", qa, TA);
    else n_pass++;
  endtask

  task automatic test_hold();
    int first = -1;
    do_reset();
    det_a = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      if (e == 21) det_a = 1'b0;
      step();
      if (first < 0 && qa != 4'd0) first = e;
    end
    n_checks++;
    if (first != 7) $display("FAIL hold_latency: first increment at edge %0d expected 7", first);
    else n_pass++;
    n_checks++;
    if (qa !== 4'd1 || TA !== 1'b1) $display("FAIL hold_single: qa=%0d TA=%b expected 1 1", qa, TA);
    else n_pass++;
  endtask

  task automatic test_drain();
    do_reset();
    arrive(0, 3);
    n_checks++;
    if (qa !== 4'd3) $display("FAIL drain_fill: qa=%0d expected 3", qa);
    else n_pass++;
    GA = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      step();
      if (e == 7 || e == 8 || e == 16 || e == 24) begin
        n_checks++;
        if (int'(qa) != ((e == 7) ? 3 : (e == 8) ? 2 : (e == 16) ? 1 : 0) ||
            TA !== (e != 24)) begin
          $display("FAIL drain_edge%0d: qa=%0d TA=%b expected %0d %b", e, qa, TA,
                   (e == 7) ? 3 : (e == 8) ? 2 : (e == 16) ? 1 : 0, e != 24);
        end else n_pass++;
      end
    end
    GA = 1'b0;
    arrive(0, 2);
    GA = 1'b1;
    for (int i = 0; i < 5; i++) step();
    GA = 1'b0;
    step(); step();
    n_checks++;
    if (qa !== 4'd2) $display("FAIL drain_partial: qa=%0d expected 2", qa);
    else n_pass++;
    GA = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 7 || e == 8) begin
        n_checks++;
        if (int'(qa) != ((e == 7) ? 2 : 1)) begin
          $display("FAIL drain_resume%0d: qa=%0d expected %0d", e, qa, (e == 7) ? 2 : 1);
        end else n_pass++;
      end
    end
    GA = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    arrive(1, 15);
    n_checks++;
    if (qb !== 4'd15 || ovf_b !== 1'b0) begin
      $display("FAIL sat_full: qb=%0d ovf_b=%b expected 15 0", qb, ovf_b);
    end else n_pass++;
    arrive(1, 1);
    n_checks++;
    if (qb !== 4'd15 || ovf_b !== 1'b1 || TB !== 1'b1) begin
      $display("FAIL sat_overflow: qb=%0d ovf_b=%b TB=%b expected 15 1 1", qb, ovf_b, TB);
    end else n_pass++;
    n_checks++;
    if (qa !== 4'd0 || ovf_a !== 1'b0 || TA !== 1'b0) begin
      $display("FAIL sat_lane_a: qa=%0d ovf_a=%b TA=%b expected 0 0 0", qa, ovf_a, TA);
    end else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    arrive(0, 2);
    GA = 1'b1;
    step();
    det_a = 1'b1;
    for (int e = 2; e <= 19; e++) begin
      step();
      if (e == 6) det_a = 1'b0;
      if (e == 8) begin
        n_checks++;
        if (qa !== 4'd2) $display("FAIL simul_arr_dep: qa=%0d expected 2", qa);
        else n_pass++;
      end
      if (e == 16) begin
        n_checks++;
        if (qa !== 4'd1) $display("FAIL simul_next_dep: qa=%0d expected 1", qa);
        else n_pass++;
      end
    end
    rst = 1'b1; det_a = 1'b1;
    step();
    n_checks++;
    if (qa !== 4'd0 || TA !== 1'b0) $display("FAIL simul_reset: qa=%0d TA=%b expected 0 0", qa, TA);
    else n_pass++;
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 7 || e == 8) begin
        n_checks++;
        if (int'(qa) != ((e == 7) ? 1 : 0)) begin
          $display("FAIL simul_tick_restart%0d: qa=%0d expected %0d", e, qa, (e == 7) ? 1 : 0);
        end else n_pass++;
      end
    end
    det_a = 1'b0; GA = 1'b0;
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) det_a = ~det_a;
      if ($urandom_range(0, 6) == 0) det_b = ~det_b;
      if ($urandom_range(0, 24) == 0) GA = ~GA;
      if ($urandom_range(0, 30) == 0) GB = ~GB;
      rst = ($urandom_range(0, 399) == 0);
      step();
      n_checks++;
      if (int'(qa) != m_q[0] || int'(qb) != m_q[1] || TA !== (m_q[0] != 0) ||
          TB !== (m_q[1] != 0) || ovf_a !== m_ovf[0] || ovf_b !== m_ovf[1]) begin
        if (shown < 10) begin
          $display("FAIL random cycle %0d: qa=%0d qb=%0d TA=%b TB=%b ovf=%b%b expected %0d %0d %b %b %b%b",
                   c, qa, qb, TA, TB, ovf_a, ovf_b, m_q[0], m_q[1], m_q[0] != 0, m_q[1] != 0,
                   m_ovf[0], m_ovf[1]);
        end
        shown++;
      end else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_hold();
    test_drain();
    test_saturate();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
